// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file constants, FSM encoding and requester indices
package mips_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   // JAL writes its return address here; writes to r0 are architecturally discarded
   localparam logic [4:0] LINK_REG = 5'd31;
   localparam logic [4:0] ZERO_REG = 5'd0;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } arb_state_e;

   // Round-robin requester slots on the shared write port
   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - writeback request and link-write handshake bundle
interface reg_write_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      link_req;
   logic [31:0]               link_pc;
   logic                      link_ack;

   // Writeback requesters and the JAL link source
   modport master (
      output req_valid, req_addr, req_data, link_req, link_pc,
      input  req_ready, link_ack
   );

   // The arbiter that owns the bank write port
   modport slave (
      input  req_valid, req_addr, req_data, link_req, link_pc,
      output req_ready, link_ack
   );

endinterface

// File: rtl/reg_write_arbiter_rr_grant.sv
// rtl/reg_write_arbiter_rr_grant.sv - combinational round-robin picker for a shared port
module rr_grant #(
   parameter  int N     = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     valid_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   // Scan from the slot after the last winner, wrapping, and take the first valid one
   always_comb begin
      int  cand;
      logic found;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int off = 1; off <= N; off++) begin
         cand = (int'(ptr_i) + off) % N;
         if (!found && valid_i[cand]) begin
            found          = 1'b1;
            grant_o[cand]  = 1'b1;
            idx_o          = IDX_W'(cand);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register bank write-port owner: init sweep, link priority, round-robin writeback
module reg_write_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   reg_write_arbiter_if.slave   bus,
   output logic                 init_busy,
   output logic                 RegWrite,
   output logic [ADDR_W-1:0]    WriteRegister,
   output logic [DATA_W-1:0]    WriteData,
   output logic                 Jal,
   output logic [31:0]          PC
);

   import mips_pkg::*;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e          state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]   cnt_d;
   logic [IDX_W-1:0]    ptr_q;
   logic                regwrite_q;
   logic [ADDR_W-1:0]   wreg_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                jal_q;
   logic [31:0]         pc_q;

   logic [NUM_REQ-1:0]  gnt_oh;
   logic [IDX_W-1:0]    gnt_idx;
   logic                gnt_any;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;

   rr_grant #(.N(NUM_REQ)) u_rr_grant (
      .valid_i (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (gnt_oh),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   // Route the winning requester's address and data slice
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_oh[i]) begin
            sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign cnt_d = cnt_q + ADDR_W'(1);

   // Grants are combinational from state and request inputs only; the link write masks all requesters
   assign bus.req_ready = (state_q == RUN && !bus.link_req) ? gnt_oh : '0;
   assign bus.link_ack  = (state_q == RUN) && bus.link_req;
   assign init_busy     = (state_q == INIT);

   // Two-state FSM with registered bank-port outputs; reset release is already synchronous upstream
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         ptr_q      <= IDX_W'(NUM_REQ - 1);
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
         jal_q      <= 1'b0;
         pc_q       <= '0;
      end else begin
         case (state_q)
            INIT: begin
               // The bank has no reset of its own, so zero every register once
               regwrite_q <= 1'b1;
               wreg_q     <= cnt_q;
               wdata_q    <= '0;
               jal_q      <= 1'b0;
               cnt_q      <= cnt_d;
               if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (bus.link_req) begin
                  // Link write always wins and leaves the round-robin pointer untouched
                  regwrite_q <= 1'b1;
                  jal_q      <= 1'b1;
                  pc_q       <= bus.link_pc;
                  wreg_q     <= ADDR_W'(LINK_REG);
                  wdata_q    <= '0;
               end else if (gnt_any) begin
                  // r0 writes are consumed but never enabled on the bank
                  regwrite_q <= (sel_addr != ADDR_W'(ZERO_REG));
                  wreg_q     <= sel_addr;
                  wdata_q    <= sel_data;
                  jal_q      <= 1'b0;
                  ptr_q      <= gnt_idx;
               end else begin
                  regwrite_q <= 1'b0;
                  jal_q      <= 1'b0;
               end
            end
         endcase
      end
   end

   assign RegWrite      = regwrite_q;
   assign WriteRegister = wreg_q;
   assign WriteData     = wdata_q;
   assign Jal           = jal_q;
   assign PC            = pc_q;

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Owns the single write port of the 32x32 register bank and shares it between writeback requesters: ALU result, load data, and the JAL link write.
- After reset it runs an init sweep that zeroes every register. The bank itself has no reset, so this sweep replaces one.
- It then grants one write per cycle: link write first, round-robin among the rest.
- Outputs are registered and drive the bank's RegWrite/WriteRegister/WriteData/Jal/PC inputs directly.

Parameters:
NUM_REQ, 2, number of round-robin writeback requesters (index 0 = ALU, 1 = load)
DATA_W, 32, register data width
ADDR_W, 5, register address width
NUM_REGS, 32, registers swept during init (must be <= 2**ADDR_W)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a write pending
req_addr  in  NUM_REQ*ADDR_W  destination register, requester i in slice i
req_data  in  NUM_REQ*DATA_W  write data, requester i in slice i
req_ready  out  NUM_REQ  combinational grant; transfer when valid&ready
link_req  in  1  JAL link write pending
link_pc  in  32  PC of the JAL instruction
link_ack  out  1  combinational grant for link write
init_busy  out  1  high while init sweep runs
RegWrite  out  1  bank write enable (registered)
WriteRegister  out  ADDR_W  bank write address (registered)
WriteData  out  DATA_W  bank write data (registered)
Jal  out  1  bank link-write select (registered)
PC  out  32  bank PC input for link write (registered)

Behaviour:
- Clock is clock; reset is reset_n, asynchronous assert, active-low, synchronous release by design.
- Reset values (immediately on reset_n low, including mid-sweep or mid-grant):
  - state=INIT, init counter=0, rr pointer=NUM_REQ-1
  - RegWrite=0, WriteRegister=0, WriteData=0, Jal=0, PC=0
  - init_busy=1
  - req_ready=0 and link_ack=0 (combinational, forced by state)
- State INIT:
  - Each cycle registers RegWrite=1, WriteRegister=counter, WriteData=0, Jal=0; counter increments.
  - After counter==NUM_REGS-1 is issued, go to RUN.
  - The sweep takes exactly NUM_REGS cycles. init_busy falls in the first RUN cycle.
  - All req_ready and link_ack are 0; requests are held, not lost.
- State RUN, per cycle:
  - If link_req=1:
    - link_ack=1, all req_ready=0.
    - Next edge registers RegWrite=1, Jal=1, PC=link_pc, WriteRegister=31, WriteData=0.
  - Else the grant is the first i with req_valid[i]=1, scanning from pointer+1 upward with wrap at NUM_REQ.
    - Only that req_ready[i]=1.
    - Next edge registers RegWrite=(req_addr_i!=0), WriteRegister=req_addr_i, WriteData=req_data_i, Jal=0.
    - pointer<=i.
  - Writes to register 0 are accepted (ready=1, pointer advances) but issue RegWrite=0.
  - No grant: RegWrite=0, Jal=0; WriteRegister/WriteData/PC hold.
- Latency: accepted request appears on the bank port exactly 1 cycle after the transfer edge. The bank commits it on the following edge.
- Link priority is absolute; requesters stall while link_req stays high. The pointer does not move on link grants.
- ready depends on valid and state only, never on itself. A requester may drop valid without a transfer.
- The FSM has exactly two states; there is no return to INIT except via reset.

Decomposition:
- Shared package (mips_pkg): ADDR_W/DATA_W constants, LINK_REG=5'd31, ZERO_REG=5'd0, state encoding (INIT=1'b0, RUN=1'b1), requester index names (REQ_ALU=0, REQ_LOAD=1).
- One natural sub-module: rr_grant. It is a combinational round-robin picker (inputs: valid vector, pointer; outputs: one-hot grant, index, any) and is reusable for other shared ports.
- The FSM, init counter and output registers stay in the top.

Test Plan:
1. Release reset_n at t0 with all requests idle -> RegWrite=1 for exactly 32 cycles, WriteRegister 0..31, WriteData=0; init_busy falls in cycle 33; req_ready=0 throughout the sweep.
2. After init, req_valid=2'b11 held for 4 cycles (ALU addr 5 data 0x11, load addr 6 data 0x22) -> grants alternate ALU, load, ALU, load starting with ALU (pointer reset =1); bank port shows reg5=0x11, reg6=0x22 alternately, one cycle after each grant.
3. link_req=1, link_pc=0x40 with req_valid=2'b01 in the same cycle -> link_ack=1, req_ready=0; next cycle Jal=1, PC=0x40, RegWrite=1; ALU is granted the following cycle.
4. ALU request to addr 0, data 0xFFFFFFFF -> req_ready=1, next cycle RegWrite=0; pointer advanced so a simultaneous load request wins next.
5. Assert reset_n=0 in RUN while a grant is in flight -> RegWrite, Jal and ready drop to 0 immediately; after release the full 32-cycle sweep repeats from register 0.
6. Request asserted during INIT (load, addr 9, data 0x33) -> held with ready=0 until the first RUN cycle, then granted; WriteRegister=9 one cycle later.
